// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache in
// front of a slow internal backing RAM. One word per line. busy stalls the
// core on read misses and on every write.
// Optional build macro: DCACHE_STATS_EN adds saturating hits/misses counters.
module data_cache #(
  parameter int NBITS     = 8,
  parameter int NLINES    = 8,
  parameter int MISS_LAT  = 4,
  parameter int WRITE_LAT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [NBITS-1:0] Address,
  input  logic [NBITS-1:0] WriteData,
  output logic [NBITS-1:0] ReadData,
  output logic             busy
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]      hits,
  output logic [15:0]      misses
`endif
);

  localparam int IDX_W   = $clog2(NLINES);
  localparam int TAG_W   = NBITS - IDX_W;
  localparam int CNT_MAX = (MISS_LAT > WRITE_LAT) ? MISS_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RMISS = 2'd1,
    WBUSY = 2'd2,
    WDONE = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  // Line storage and backing RAM
  logic [NLINES-1:0] line_valid;
  logic [TAG_W-1:0]  line_tag  [NLINES];
  logic [NBITS-1:0]  line_data [NLINES];
  logic [NBITS-1:0]  backing   [2**NBITS];

  // Request captured at acceptance so an in-flight operation completes even
  // if the core drops or changes its request.
  logic [NBITS-1:0] req_addr;
  logic [NBITS-1:0] req_wdata;

  logic             accept;
  logic             fill_en;
  logic             wr_en;
  logic             busy_raw;
  logic [NBITS-1:0] rdata_raw;

  // Lookup on the live address (IDLE) and on the captured address (WBUSY/RMISS)
  logic [IDX_W-1:0] cur_idx, req_idx;
  logic [TAG_W-1:0] cur_tag, req_tag;
  logic             cur_hit, req_hit;

  assign cur_idx = Address[IDX_W-1:0];
  assign cur_tag = Address[NBITS-1:IDX_W];
  assign cur_hit = line_valid[cur_idx] && (line_tag[cur_idx] == cur_tag);
  assign req_idx = req_addr[IDX_W-1:0];
  assign req_tag = req_addr[NBITS-1:IDX_W];
  assign req_hit = line_valid[req_idx] && (line_tag[req_idx] == req_tag);

  // State and latency counter register
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, counter and combinational outputs
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_next = state;
    cnt_next   = cnt;
    busy_raw   = 1'b0;
    rdata_raw  = '0;
    accept     = 1'b0;
    fill_en    = 1'b0;
    wr_en      = 1'b0;
    unique case (state)
      IDLE: begin
        if (MemWrite) begin
          busy_raw   = 1'b1;
          accept     = 1'b1;
          cnt_next   = CNT_W'(WRITE_LAT - 1);
          state_next = WBUSY;
        end else if (MemRead) begin
          if (cur_hit) begin
            rdata_raw = line_data[cur_idx];
          end else begin
            busy_raw   = 1'b1;
            accept     = 1'b1;
            cnt_next   = CNT_W'(MISS_LAT - 1);
            state_next = RMISS;
          end
        end
      end
      RMISS: begin
        busy_raw = 1'b1;
        if (cnt == '0) begin
          fill_en    = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      WBUSY: begin
        busy_raw = 1'b1;
        if (cnt == '0) begin
          wr_en      = 1'b1;
          state_next = WDONE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      WDONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are forced low while reset is asserted, independent of the clock
  // and of whatever request the core is still holding.
  assign busy     = reset & busy_raw;
  assign ReadData = reset ? rdata_raw : '0;

  // Capture the request when it is accepted in IDLE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_addr  <= '0;
      req_wdata <= '0;
    end else if (accept) begin
      req_addr  <= Address;
      req_wdata <= WriteData;
    end
  end

  // Valid bits: cleared by reset, set on a fill
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      line_valid <= '0;
    end else if (fill_en) begin
      line_valid[req_idx] <= 1'b1;
    end
  end

  // Line tag/data and backing RAM updates
  always_ff @(posedge clock) begin
    // NOTE: storage arrays carry no reset; valid bits alone decide what is live.
    if (fill_en) begin
      line_tag[req_idx]  <= req_tag;
      line_data[req_idx] <= backing[req_addr];
    end
    if (wr_en) begin
      backing[req_addr] <= req_wdata;
      if (req_hit) begin
        line_data[req_idx] <= req_wdata;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic refill;
  logic stat_hit;
  logic stat_miss;

  assign stat_miss = (state == IDLE) && !MemWrite && MemRead && !cur_hit;
  assign stat_hit  = (state == IDLE) && !MemWrite && MemRead && cur_hit;

  // Saturating hit/miss counters; the hit right after a fill is not counted
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hits   <= '0;
      misses <= '0;
      refill <= 1'b0;
    end else begin
      refill <= fill_en;
      if (stat_miss && (misses != '1)) begin
        misses <= misses + 1'b1;
      end
      if (stat_hit && !refill && (hits != '1)) begin
        hits <= hits + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache (default parameters). Expected read data
// goes through a scoreboard queue; a small reference model of backing memory
// and line residency predicts hit/miss and busy lengths.
module tb_data_cache;

  localparam int MISS_LAT  = 4;
  localparam int WRITE_LAT = 2;

  logic       clock;
  logic       reset;
  logic       MemRead;
  logic       MemWrite;
  logic [7:0] Address;
  logic [7:0] WriteData;
  logic [7:0] ReadData;
  logic       busy;
`ifdef DCACHE_STATS_EN
  logic [15:0] hits;
  logic [15:0] misses;
`endif

  data_cache #(
    .NBITS(8), .NLINES(8), .MISS_LAT(MISS_LAT), .WRITE_LAT(WRITE_LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .busy      (busy)
`ifdef DCACHE_STATS_EN
    ,
    .hits      (hits),
    .misses    (misses)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [7:0] ref_mem   [256];
  logic       ref_valid [8];
  logic [4:0] ref_tag   [8];
  logic [7:0] exp_q [$];
  logic [7:0] pool [6] = '{8'h13, 8'h0B, 8'h40, 8'h1B, 8'h23, 8'h05};

  function automatic bit ref_hit(input logic [7:0] a);
    return ref_valid[a[2:0]] && (ref_tag[a[2:0]] == a[7:3]);
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
  endtask

  // Read a word; all tasks start and end 1ns after a rising edge
  task automatic do_read(input logic [7:0] a, input string tag);
    int         nb;
    int         exp_busy;
    logic [7:0] exp;
    exp_busy = ref_hit(a) ? 0 : 1 + MISS_LAT;
    exp_q.push_back(ref_mem[a]);
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    Address  = a;
    nb = 0;
    @(negedge clock);
    while (busy && nb < 50) begin
      nb++;
      if (nb == 1) check({tag, " rdata during miss"}, ReadData, 0);
      @(negedge clock);
    end
    check({tag, " busy cycles"}, nb, exp_busy);
    exp = exp_q.pop_front();
    check({tag, " rdata"}, ReadData, exp);
    ref_valid[a[2:0]] = 1'b1;
    ref_tag[a[2:0]]   = a[7:3];
    @(posedge clock);
    #1;
    MemRead = 1'b0;
  endtask

  // Write a word, optionally with MemRead also high
  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input bit both, input string tag);
    int nb;
    MemWrite  = 1'b1;
    MemRead   = both;
    Address   = a;
    WriteData = d;
    nb = 0;
    @(negedge clock);
    while (busy && nb < 50) begin
      nb++;
      @(negedge clock);
    end
    check({tag, " busy cycles"}, nb, 1 + WRITE_LAT);
    check({tag, " rdata in WDONE"}, ReadData, 0);
    ref_mem[a] = d;
    @(posedge clock);
    #1;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    @(negedge clock);
    check({tag, " idle after WDONE"}, busy, 0);
    @(posedge clock);
    #1;
  endtask

  // Read miss whose request is dropped after two busy cycles
  task automatic do_read_drop(input logic [7:0] a);
    int nb;
    MemRead = 1'b1;
    Address = a;
    nb = 0;
    @(negedge clock);
    while (busy && nb < 50) begin
      nb++;
      if (nb == 2) MemRead = 1'b0;
      @(negedge clock);
    end
    check("dropped read busy cycles", nb, 1 + MISS_LAT);
    ref_valid[a[2:0]] = 1'b1;
    ref_tag[a[2:0]]   = a[7:3];
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    #2;
    reset = 1'b0;
    ref_clear();
    #2;
    check("busy in reset", busy, 0);
`ifdef DCACHE_STATS_EN
    check("hits cleared", hits, 0);
    check("misses cleared", misses, 0);
`endif
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_clear();
    reset     = 1'b0;
    MemRead   = 1'b1;
    MemWrite  = 1'b0;
    Address   = 8'h13;
    WriteData = 8'h00;
    #3;
    check("reset busy with request held", busy, 0);
    check("reset rdata", ReadData, 0);
    MemRead = 1'b0;
    #9;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("idle busy", busy, 0);
    check("idle rdata", ReadData, 0);

    // Preload backing RAM through the port, then reset (RAM survives reset)
    for (int i = 0; i < 6; i++) do_write(pool[i], 8'h20 + 8'(i), 1'b0, "preload");
    do_write(8'h13, 8'h5A, 1'b0, "preload 13");
    pulse_reset();

    do_read(8'h13, "first 13");
    do_read(8'h13, "hit 13");
`ifdef DCACHE_STATS_EN
    check("hits after two reads", hits, 1);
    check("misses after two reads", misses, 1);
`endif

    do_write(8'h13, 8'hC3, 1'b0, "write 13");
    do_read(8'h13, "hit 13 after write");
    check("backing 13", dut.backing[8'h13], 8'hC3);

    do_write(8'h40, 8'h77, 1'b0, "cold write 40");
    do_read(8'h40, "read 40");

    do_read(8'h0B, "conflict 0B");
    do_read(8'h13, "re-miss 13");

    do_write(8'h0B, 8'h99, 1'b1, "write+read 0B");
    do_read(8'h0B, "read 0B");

    do_read_drop(8'h1B);
    do_read(8'h1B, "hit after dropped read");

    // Reset during the third RMISS cycle of a miss on 0x13
    do_read(8'h0B, "evict 13");
    begin
      int nb;
      nb = 0;
      MemRead = 1'b1;
      Address = 8'h13;
      for (int c = 0; c < 4; c++) begin
        @(negedge clock);
        if (busy) nb++;
      end
      check("busy cycles before reset", nb, 4);
      reset = 1'b0;
      #1;
      check("busy drops on reset", busy, 0);
      check("rdata on reset", ReadData, 0);
      MemRead = 1'b0;
      ref_clear();
      #2;
      reset = 1'b1;
      @(posedge clock);
      #1;
    end
    do_read(8'h13, "miss 13 after reset");
`ifdef DCACHE_STATS_EN
    check("misses after reset read", misses, 1);
`endif

    // Random traffic over the preloaded address pool
    for (int i = 0; i < 16; i++) begin
      logic [7:0] a;
      a = pool[$urandom_range(0, 5)];
      if ($urandom_range(0, 2) == 0)
        do_write(a, 8'($urandom), $urandom_range(0, 1) == 1, "rand write");
      else
        do_read(a, "rand read");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
